// File: rtl/mpsoc_ahb3_pkg.sv
// mpsoc_ahb3_pkg: shared AHB3-Lite encodings for masters and slaves
package mpsoc_ahb3_pkg;
   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [2:0] HBURST_SINGLE = 3'b000;
   localparam logic [2:0] HSIZE_BYTE    = 3'b000;
   localparam logic [2:0] HSIZE_HWORD   = 3'b001;
   localparam logic [2:0] HSIZE_WORD    = 3'b010;
   localparam logic [2:0] HSIZE_DWORD   = 3'b011;
   localparam logic       HRESP_OKAY    = 1'b0;
   localparam logic       HRESP_ERROR   = 1'b1;
   localparam logic [3:0] HPROT_DEFAULT = 4'b0011;
endpackage

// File: rtl/mpsoc_ahb3_master.sv
// mpsoc_ahb3_master: valid/ready request stream to pipelined AHB3-Lite SINGLE transfers
module mpsoc_ahb3_master
   import mpsoc_ahb3_pkg::*;
#(
   parameter int         PLEN      = 32,
   parameter int         XLEN      = 32,
   parameter logic [3:0] HPROT_VAL = HPROT_DEFAULT
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [PLEN-1:0] req_addr,
   input  logic [XLEN-1:0] req_wdata,
   input  logic            req_we,
   input  logic [2:0]      req_size,
   output logic            rsp_valid,
   output logic [XLEN-1:0] rsp_rdata,
   output logic            rsp_err,
   output logic            HSEL,
   output logic [PLEN-1:0] HADDR,
   output logic [XLEN-1:0] HWDATA,
   output logic            HWRITE,
   output logic [2:0]      HSIZE,
   output logic [2:0]      HBURST,
   output logic [3:0]      HPROT,
   output logic [1:0]      HTRANS,
   output logic            HMASTLOCK,
   input  logic            HREADY,
   input  logic [XLEN-1:0] HRDATA,
   input  logic            HRESP
);
   logic            a_valid, a_we, d_valid, d_we, err;
   logic [PLEN-1:0] a_addr;
   logic [2:0]      a_size;
   logic [XLEN-1:0] a_wdata, d_wdata;
   logic            advance, accept, done;

   assign advance   = HREADY & (HRESP == HRESP_OKAY);
   assign req_ready = ~rst & (~a_valid | advance);
   assign accept    = req_valid & req_ready;
   assign done      = d_valid & HREADY;

   assign HSEL      = a_valid;
   assign HADDR     = a_addr;
   assign HWRITE    = a_we;
   assign HSIZE     = a_size;
   assign HWDATA    = d_wdata;
   // HRESP feeds HTRANS directly so the address phase is withdrawn in the first ERROR cycle
   assign HTRANS    = (a_valid & ~HRESP & ~err) ? HTRANS_NONSEQ : HTRANS_IDLE;
   assign HBURST    = HBURST_SINGLE;
   assign HPROT     = HPROT_VAL;
   assign HMASTLOCK = 1'b0;

   always_ff @(posedge clk)
      if (rst) begin
         a_valid   <= 1'b0;
         a_we      <= 1'b0;
         a_addr    <= '0;
         a_size    <= '0;
         a_wdata   <= '0;
         d_valid   <= 1'b0;
         d_we      <= 1'b0;
         d_wdata   <= '0;
         err       <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         rsp_rdata <= '0;
      end else begin
         err <= HRESP & ~HREADY;
         if (accept) begin
            a_valid <= 1'b1;
            a_addr  <= req_addr;
            a_we    <= req_we;
            a_size  <= req_size;
            a_wdata <= req_wdata;
         end else if (advance)
            a_valid <= 1'b0;
         if (advance) begin
            d_valid <= a_valid;
            d_we    <= a_we;
            d_wdata <= a_wdata;
         end else if (HRESP & HREADY)
            d_valid <= 1'b0;
         rsp_valid <= done;
         rsp_err   <= done & HRESP;
         rsp_rdata <= (done & ~HRESP & ~d_we) ? HRDATA : '0;
      end
endmodule

// File: tb/tb_mpsoc_ahb3_master.sv
// tb_mpsoc_ahb3_master: randomized traffic against a reactive AHB slave and an in-order scoreboard
module tb_mpsoc_ahb3_master;
   logic        clk = 0, rst = 1;
   logic        req_valid = 0, req_we = 0, req_ready;
   logic [31:0] req_addr = 0, req_wdata = 0;
   logic [2:0]  req_size = 3'b010;
   logic        rsp_valid, rsp_err;
   logic [31:0] rsp_rdata;
   logic        HSEL, HWRITE, HMASTLOCK;
   logic [31:0] HADDR, HWDATA;
   logic [2:0]  HSIZE, HBURST;
   logic [3:0]  HPROT;
   logic [1:0]  HTRANS;
   logic        HREADY = 1, HRESP = 0;
   logic [31:0] HRDATA = 0;

   mpsoc_ahb3_master dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_we(req_we), .req_size(req_size),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .HSEL(HSEL), .HADDR(HADDR), .HWDATA(HWDATA), .HWRITE(HWRITE),
      .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HTRANS(HTRANS),
      .HMASTLOCK(HMASTLOCK), .HREADY(HREADY), .HRDATA(HRDATA), .HRESP(HRESP)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          cyc;
      int          lat;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] model_mem [64];
   logic [31:0] smem [64];
   int          vectors = 0, miscompares = 0, cyc = 0, wmax = 0, last_tries = 0;
   bit          err_en = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   function automatic bit bad(input logic [31:0] a);
      return a[6] && a[4:2] == 3'b000;
   endfunction

   // Slave: one data phase at a time, random wait count, optional two-cycle ERROR
   logic       dp_v = 0, dp_w = 0, dp_e = 0;
   logic [5:0] dp_i = 0;
   int         dp_wt = 0, st = 0;

   always @(posedge clk) begin
      if (rst) dp_v = 0;
      else if (HREADY) begin
         if (dp_v && dp_w && !dp_e) smem[dp_i] = HWDATA;
         dp_v  = HSEL && HTRANS == 2'b10;
         dp_i  = HADDR[7:2];
         dp_w  = HWRITE;
         dp_e  = err_en && bad(HADDR);
         dp_wt = $urandom_range(wmax, 0);
         st    = 0;
      end else st++;
   end

   logic        p_wait = 0, p_sel = 0;
   logic [31:0] p_addr = 0, p_wdata = 0;

   always @(negedge clk) begin
      exp_t e;
      cyc++;
      HREADY = 1;
      HRESP  = 0;
      HRDATA = $urandom;
      if (dp_v) begin
         if (st < dp_wt) HREADY = 0;
         else if (dp_e) begin
            HRESP  = 1;
            HREADY = st > dp_wt;
         end else if (!dp_w) HRDATA = smem[dp_i];
      end
      #1;
      if (rsp_valid) begin
         if (exp_q.size() == 0) check("rsp_spurious", 1, 0);
         else begin
            e = exp_q.pop_front();
            check("rsp_rdata", rsp_rdata, e.rdata);
            check("rsp_err", rsp_err, e.err);
            if (e.lat != 0) check("rsp_latency", cyc, e.cyc + e.lat);
         end
      end
      if (HRESP) check("htrans_idle_on_error", HTRANS, 2'b00);
      if (!rst && HSEL && !(HREADY && !HRESP)) check("req_ready_stall", req_ready, 0);
      if (p_wait) begin
         check("hwdata_hold", HWDATA, p_wdata);
         if (p_sel) check("haddr_hold", HADDR, p_addr);
      end
      p_wait  = !HREADY && !HRESP && !rst;
      p_sel   = HSEL;
      p_addr  = HADDR;
      p_wdata = HWDATA;
   end

   // Called at negedge+2; returns at negedge+2 of the cycle after acceptance
   task automatic send(input logic [31:0] a, input logic w, input logic [31:0] d, input int lat);
      int   n = 0;
      logic rdy;
      exp_t e;
      req_valid = 1;
      req_addr  = a;
      req_we    = w;
      req_wdata = d;
      req_size  = 3'($urandom_range(3, 0));
      #1 rdy = req_ready;
      while (!rdy && n < 200) begin
         @(negedge clk);
         #3 rdy = req_ready;
         n++;
      end
      e.cyc = cyc;
      @(posedge clk);
      if (!rdy) check("send_timeout", 0, 1);
      else begin
         e.err   = err_en && bad(a);
         e.rdata = (e.err || w) ? 32'h0 : model_mem[a[7:2]];
         if (w && !e.err) model_mem[a[7:2]] = d;
         e.lat = lat;
         exp_q.push_back(e);
      end
      last_tries = n;
      @(negedge clk);
      #2;
   endtask

   task automatic idle(input int n);
      req_valid = 0;
      repeat (n) begin
         @(negedge clk);
         #2;
      end
   endtask

   task automatic drain();
      int n = 0;
      req_valid = 0;
      while (exp_q.size() != 0 && n < 100) begin
         @(negedge clk);
         #2;
         n++;
      end
      check("drain_empty", exp_q.size(), 0);
      idle(3);
   endtask

   task automatic chk_reset();
      check("rst_htrans", HTRANS, 2'b00);
      check("rst_hsel", HSEL, 0);
      check("rst_haddr", HADDR, 0);
      check("rst_hwdata", HWDATA, 0);
      check("rst_hwrite", HWRITE, 0);
      check("rst_hsize", HSIZE, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_err", rsp_err, 0);
      check("rst_rsp_rdata", rsp_rdata, 0);
      check("rst_req_ready", req_ready, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int stalls;
      for (int i = 0; i < 64; i++) begin
         model_mem[i] = 32'h1357_0000 + 32'(i);
         smem[i]      = 32'h1357_0000 + 32'(i);
      end
      repeat (3) @(negedge clk);
      #2;
      chk_reset();
      check("hburst", HBURST, 3'b000);
      check("hprot", HPROT, 4'b0011);
      check("hmastlock", HMASTLOCK, 0);
      rst = 0;
      idle(1);
      check("ready_after_rst", req_ready, 1);
      send(32'h10, 1, 32'hDEADBEEF, 3);
      send(32'h10, 0, 32'h0, 3);
      drain();
      stalls = 0;
      for (int i = 0; i < 8; i++) begin
         send(32'(i * 4), 0, 32'h0, 3);
         stalls += last_tries;
      end
      check("b2b_stalls", stalls, 0);
      drain();
      wmax   = 2;
      err_en = 1;
      repeat (300) begin
         if ($urandom_range(3, 0) == 0) idle(1);
         else send({24'h0, 6'($urandom_range(63, 0)), 2'b00}, 1'($urandom_range(1, 0)), $urandom, 0);
      end
      drain();
      wmax = 0;
      send(32'h40, 0, 32'h0, 4);
      send(32'h44, 0, 32'h0, 5);
      drain();
      err_en = 0;
      send(32'h20, 0, 32'h0, 3);
      send(32'h24, 0, 32'h0, 3);
      req_valid = 0;
      rst = 1;
      exp_q.delete();
      @(negedge clk);
      #2;
      chk_reset();
      rst = 0;
      send(32'h28, 0, 32'h0, 3);
      check("rst_accept_tries", last_tries, 0);
      drain();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
